// File: rtl/cluster_pkg.sv
// Shared types and constants for the S-bit cluster counter and its window sequencer.
package cluster_pkg;

    localparam int CNT_W                = 11;
    localparam int CLUSTER_OVF_THRESH   = 8;
    localparam int COUNTER_PIPE_LATENCY = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_ACCUM = 2'd2
    } state_e;

endpackage

// File: rtl/window_accum.sv
// Saturating sum / peak / overflow-cycle accumulators for one integration window.
// The *_next outputs already include the current sample so the caller can capture a final result.
module window_accum
    import cluster_pkg::*;
#(
    parameter int SUM_W = 32,
    parameter int OVF_W = 24
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clear_i,
    input  logic             sample_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             overflow_i,
    output logic [SUM_W-1:0] sum_next_o,
    output logic [CNT_W-1:0] peak_next_o,
    output logic [OVF_W-1:0] ovf_next_o
);

    // One spare bit above the wider operand catches the carry for saturation.
    localparam int EXT_W  = ((SUM_W > CNT_W) ? SUM_W : CNT_W) + 1;
    localparam int OVF_EW = OVF_W + 1;

    logic [SUM_W-1:0]  sum_q;
    logic [CNT_W-1:0]  peak_q;
    logic [OVF_W-1:0]  ovf_q;
    logic [EXT_W-1:0]  sum_wide;
    logic [OVF_EW-1:0] ovf_wide;

    always_comb begin
        sum_wide = EXT_W'(sum_q) + EXT_W'(cnt_i);
        if (sum_wide > EXT_W'({SUM_W{1'b1}})) begin
            sum_next_o = '1;
        end else begin
            sum_next_o = sum_wide[SUM_W-1:0];
        end

        peak_next_o = (cnt_i > peak_q) ? cnt_i : peak_q;

        ovf_wide   = OVF_EW'(ovf_q) + OVF_EW'(overflow_i);
        ovf_next_o = ovf_wide[OVF_W] ? '1 : ovf_wide[OVF_W-1:0];
    end

    // Clear beats sample so a window-end cycle restarts from zero.
    always_ff @(posedge clk) begin
        if (srst || clear_i) begin
            sum_q  <= '0;
            peak_q <= '0;
            ovf_q  <= '0;
        end else if (sample_i) begin
            sum_q  <= sum_next_o;
            peak_q <= peak_next_o;
            ovf_q  <= ovf_next_o;
        end
    end

endmodule

// File: rtl/cluster_count_window_ctrl.sv
// Window sequencer for the pipelined cluster counter: flush, accumulate, publish via valid/ready.
module cluster_count_window_ctrl
    import cluster_pkg::*;
#(
    parameter int PIPE_LATENCY = COUNTER_PIPE_LATENCY,
    parameter int WIN_W        = 24,
    parameter int SUM_W        = 32,
    parameter int OVF_W        = 24
) (
    input  logic             clock4x,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             overflow_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             continuous_i,
    input  logic [WIN_W-1:0] window_len_i,
    input  logic             result_ready_i,
    output logic             result_valid_o,
    output logic [SUM_W-1:0] sum_o,
    output logic [CNT_W-1:0] peak_o,
    output logic [OVF_W-1:0] ovf_cycles_o,
    output logic             busy_o,
    output logic [15:0]      dropped_o
);

    localparam int FLUSH_W = (PIPE_LATENCY > 0) ? $clog2(PIPE_LATENCY + 1) : 1;

    state_e             state_q, state_d;
    logic [FLUSH_W-1:0] flush_q, flush_d;
    logic [WIN_W-1:0]   samp_q, samp_d;
    logic [WIN_W-1:0]   win_len_q, win_len_d;
    logic               cont_q, cont_d;
    logic               valid_q, valid_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   peak_q, peak_d;
    logic [OVF_W-1:0]   ovf_q, ovf_d;
    logic [15:0]        dropped_q, dropped_d;

    logic               acc_clear;
    logic               acc_sample;
    logic               win_end;
    logic [SUM_W-1:0]   acc_sum;
    logic [CNT_W-1:0]   acc_peak;
    logic [OVF_W-1:0]   acc_ovf;

    window_accum #(
        .SUM_W(SUM_W),
        .OVF_W(OVF_W)
    ) u_accum (
        .clk        (clock4x),
        .srst       (reset),
        .clear_i    (acc_clear),
        .sample_i   (acc_sample),
        .cnt_i      (cnt_i),
        .overflow_i (overflow_i),
        .sum_next_o (acc_sum),
        .peak_next_o(acc_peak),
        .ovf_next_o (acc_ovf)
    );

    always_comb begin
        state_d    = state_q;
        flush_d    = flush_q;
        samp_d     = samp_q;
        win_len_d  = win_len_q;
        cont_d     = cont_q;
        acc_clear  = 1'b0;
        acc_sample = 1'b0;
        win_end    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    win_len_d = (window_len_i == '0) ? WIN_W'(1) : window_len_i;
                    cont_d    = continuous_i;
                    acc_clear = 1'b1;
                    samp_d    = '0;
                    if (PIPE_LATENCY == 0) begin
                        state_d = ST_ACCUM;
                    end else begin
                        state_d = ST_FLUSH;
                        flush_d = FLUSH_W'(PIPE_LATENCY);
                    end
                end
            end
            ST_FLUSH: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_d = flush_q - FLUSH_W'(1);
                    if (flush_q <= FLUSH_W'(1)) begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (stop_i) begin
                    state_d   = ST_IDLE;
                    acc_clear = 1'b1;
                    samp_d    = '0;
                end else begin
                    acc_sample = 1'b1;
                    // samp_q counts samples already taken, so this is the last one.
                    if (samp_q == win_len_q - WIN_W'(1)) begin
                        win_end   = 1'b1;
                        acc_clear = 1'b1;
                        samp_d    = '0;
                        if (!cont_q) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        samp_d = samp_q + WIN_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        valid_d   = valid_q;
        sum_d     = sum_q;
        peak_d    = peak_q;
        ovf_d     = ovf_q;
        dropped_d = dropped_q;

        // A consumer accepting on the window-end cycle frees the slot for the new result.
        if (win_end) begin
            if (!valid_q || result_ready_i) begin
                valid_d = 1'b1;
                sum_d   = acc_sum;
                peak_d  = acc_peak;
                ovf_d   = acc_ovf;
            end else if (dropped_q != '1) begin
                dropped_d = dropped_q + 16'd1;
            end
        end else if (valid_q && result_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock4x) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            flush_q   <= '0;
            samp_q    <= '0;
            win_len_q <= '0;
            cont_q    <= 1'b0;
            valid_q   <= 1'b0;
            sum_q     <= '0;
            peak_q    <= '0;
            ovf_q     <= '0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            samp_q    <= samp_d;
            win_len_q <= win_len_d;
            cont_q    <= cont_d;
            valid_q   <= valid_d;
            sum_q     <= sum_d;
            peak_q    <= peak_d;
            ovf_q     <= ovf_d;
            dropped_q <= dropped_d;
        end
    end

    assign result_valid_o = valid_q;
    assign sum_o          = sum_q;
    assign peak_o         = peak_q;
    assign ovf_cycles_o   = ovf_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign dropped_o      = dropped_q;

endmodule
